id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the 5-stage MIPS32 pipeline. Sits between IF/ID and EX, and drives the register file's two read ports. Decodes the instruction and resolves operands with EX/MEM forwarding. Detects load-use hazards, resolves BEQ/BNE in ID (one delay slot, no flush), and registers the decoded micro-op into the ID/EX pipeline register.

## Interface
Parameters: none.
Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; clears the ID/EX register.
- if_pc  in  32  PC of the instruction in ID.
- if_inst  in  32  instruction word in ID.
- if_valid  in  1  if_inst is a real instruction.
- re_1 / raddr_1  out  1 / 5  regfile read port 1 enable / address (rs).
- rdata_1  in  32  regfile read data 1 (already bypasses the WB write).
- re_2 / raddr_2  out  1 / 5  regfile read port 2 enable / address (rt).
- rdata_2  in  32  regfile read data 2.
- ex_we, ex_waddr, ex_wdata, ex_is_load  in  1,5,32,1  EX-stage result, for forwarding.
- mem_we, mem_waddr, mem_wdata  in  1,5,32  MEM-stage result, for forwarding.
- stall_in  in  1  downstream stall; hold ID/EX.
- stall_req  out  1  freeze PC and IF/ID (combinational).
- branch_taken  out  1  redirect IF (combinational).
- branch_target  out  32  redirect address.
- idex_valid, idex_aluop[3:0], idex_opnd1[31:0], idex_opnd2[31:0], idex_store_data[31:0], idex_waddr[4:0], idex_we, idex_mem_rd, idex_mem_wr  out  registered ID/EX fields.

## Operation
- Supported instructions and decode:
  - SPECIAL funct ADDU 100001 → ADD; SUBU 100011 → SUB; AND 100100 → AND; OR 100101 → OR; XOR 100110 → XOR; SLT 101010 → SLT. Dest rd; reads rs, rt.
  - ORI 001101: OR, zero-extended imm. ANDI 001100: AND, zero-extended imm. ADDIU 001001: ADD, sign-extended imm. Dest rt; reads rs.
  - LUI 001111: OR, opnd1=0, opnd2={imm,16'h0}. Dest rt; no reads.
  - LW 100011: ADD rs + sext(imm), mem_rd=1, dest rt.
  - SW 101011: ADD rs + sext(imm), mem_wr=1, store_data = fwd(rt), we=0.
  - BEQ 000100 / BNE 000101: read rs and rt; we=0; aluop NOP.
- Anything else, including the all-zero word: NOP (aluop 0, we/mem_rd/mem_wr=0), idex_valid=1.
- aluop encoding: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT.
- re_x is forced to 0 when if_valid=0.
- Operand forwarding, per port, first match wins:
  1. Address is 0 → 0.
  2. ex_we && ex_waddr==addr → ex_wdata.
  3. mem_we && mem_waddr==addr → mem_wdata.
  4. Otherwise rdata.
  - A port with re=0 yields 0.
- Load-use hazard = if_valid && ex_is_load && ex_we && ex_waddr!=0 && ((re_1 && raddr_1==ex_waddr) || (re_2 && raddr_2==ex_waddr)).
- stall_req = hazard | stall_in.
- Branch:
  - taken = if_valid && !stall_req && (BEQ ? op1==op2 : BNE ? op1!=op2 : 0).
  - branch_target = if_pc + 4 + (sext(imm) << 2), mod 2^32.
  - The delay-slot instruction always executes.

## Timing
- Reset (rst=0, any time, asynchronous): all idex_* outputs become 0 immediately. Combinational outputs follow their inputs.
- ID/EX update on rising clk, in priority order:
  1. stall_in=1: hold all fields.
  2. Else hazard=1: insert bubble (idex_valid/we/mem_rd/mem_wr/aluop=0; other fields 0).
  3. Else if_valid=0: bubble.
  4. Else: load the decoded fields.
- Latency: instruction present in ID at cycle N → ID/EX fields valid from N+1.
- A hazard stalls exactly one cycle. The next cycle the load is in MEM and its data is forwarded via mem_*.
- Simultaneous stall_in and hazard: hold wins; stall_req=1.
- Branch with an operand produced by a load in EX: stall first, then the branch resolves in the next cycle with the forwarded value.

## Test plan
- Reset: drive rst=0 mid-run with idex_we=1 → all idex_* read 0 before the next edge. Release → first valid instruction appears one cycle later.
- ADDU $3,$1,$2 with rdata_1=5, rdata_2=7, no forwarding → next cycle aluop=1, opnd1=5, opnd2=7, waddr=3, we=1, valid=1.
- Forward priority: ORI $4,$1,0x00FF, with ex_waddr=1/ex_wdata=0x10 and mem_waddr=1/mem_wdata=0x20 (both we=1) → opnd1=0x10, opnd2=0x000000FF. Repeat with ex_we=0 → opnd1=0x20. Repeat with raddr 0 instead → opnd1=0.
- Load-use: ex_is_load=1, ex_waddr=2, ID holds SUBU $5,$2,$6 → stall_req=1 and a bubble (valid=0) is registered. Next cycle (mem_waddr=2, mem_wdata=9, ex_is_load=0) → SUBU issues with opnd1=9.
- Branch: BEQ at pc 0x100 with imm 0xFFFF and equal operands → branch_taken=1, target 0x100. Same with imm 0x0004 → target 0x114. BNE with equal operands → taken=0.
- Stall hold: stall_in=1 for 2 cycles during LW $7,8($1) → idex_* unchanged and stall_req=1 throughout. Release → LW issues with mem_rd=1, opnd2=8.

Source files
------------

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module : id_stage
// MIPS32 decode stage: decode, EX/MEM forwarding, load-use stall, BEQ/BNE
// resolution in ID, and the ID/EX pipeline register.
// Rev    : 1.0
// ============================================================================
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        if_valid,
    output logic        re_1,
    output logic [4:0]  raddr_1,
    input  logic [31:0] rdata_1,
    output logic        re_2,
    output logic [4:0]  raddr_2,
    input  logic [31:0] rdata_2,
    input  logic        ex_we,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_is_load,
    input  logic        mem_we,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        stall_in,
    output logic        stall_req,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        idex_valid,
    output logic [3:0]  idex_aluop,
    output logic [31:0] idex_opnd1,
    output logic [31:0] idex_opnd2,
    output logic [31:0] idex_store_data,
    output logic [4:0]  idex_waddr,
    output logic        idex_we,
    output logic        idex_mem_rd,
    output logic        idex_mem_wr
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;

    localparam logic [1:0] SRC2_REG  = 2'd0;
    localparam logic [1:0] SRC2_ZEXT = 2'd1;
    localparam logic [1:0] SRC2_SEXT = 2'd2;
    localparam logic [1:0] SRC2_LUI  = 2'd3;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] imm_sext;

    assign opcode   = if_inst[31:26];
    assign rs       = if_inst[25:21];
    assign rt       = if_inst[20:16];
    assign rd       = if_inst[15:11];
    assign funct    = if_inst[5:0];
    assign imm      = if_inst[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};

    logic [3:0] dec_aluop;
    logic [1:0] dec_src2;
    logic       dec_use_rs;
    logic       dec_use_rt;
    logic       dec_we;
    logic       dec_dest_rd;
    logic       dec_mem_rd;
    logic       dec_mem_wr;
    logic       dec_beq;
    logic       dec_bne;

    always_comb begin
        dec_aluop   = ALU_NOP;
        dec_src2    = SRC2_REG;
        dec_use_rs  = 1'b0;
        dec_use_rt  = 1'b0;
        dec_we      = 1'b0;
        dec_dest_rd = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU: dec_aluop = ALU_ADD;
                    FN_SUBU: dec_aluop = ALU_SUB;
                    FN_AND:  dec_aluop = ALU_AND;
                    FN_OR:   dec_aluop = ALU_OR;
                    FN_XOR:  dec_aluop = ALU_XOR;
                    FN_SLT:  dec_aluop = ALU_SLT;
                    default: dec_aluop = ALU_NOP;
                endcase
                // Unknown SPECIAL functs stay a pure NOP with no register reads.
                if (dec_aluop != ALU_NOP) begin
                    dec_use_rs  = 1'b1;
                    dec_use_rt  = 1'b1;
                    dec_we      = 1'b1;
                    dec_dest_rd = 1'b1;
                end
            end
            OP_ORI: begin
                dec_aluop  = ALU_OR;
                dec_src2   = SRC2_ZEXT;
                dec_use_rs = 1'b1;
                dec_we     = 1'b1;
            end
            OP_ANDI: begin
                dec_aluop  = ALU_AND;
                dec_src2   = SRC2_ZEXT;
                dec_use_rs = 1'b1;
                dec_we     = 1'b1;
            end
            OP_ADDIU: begin
                dec_aluop  = ALU_ADD;
                dec_src2   = SRC2_SEXT;
                dec_use_rs = 1'b1;
                dec_we     = 1'b1;
            end
            OP_LUI: begin
                dec_aluop = ALU_OR;
                dec_src2  = SRC2_LUI;
                dec_we    = 1'b1;
            end
            OP_LW: begin
                dec_aluop  = ALU_ADD;
                dec_src2   = SRC2_SEXT;
                dec_use_rs = 1'b1;
                dec_we     = 1'b1;
                dec_mem_rd = 1'b1;
            end
            OP_SW: begin
                dec_aluop  = ALU_ADD;
                dec_src2   = SRC2_SEXT;
                dec_use_rs = 1'b1;
                dec_use_rt = 1'b1;
                dec_mem_wr = 1'b1;
            end
            OP_BEQ: begin
                dec_use_rs = 1'b1;
                dec_use_rt = 1'b1;
                dec_beq    = 1'b1;
            end
            OP_BNE: begin
                dec_use_rs = 1'b1;
                dec_use_rt = 1'b1;
                dec_bne    = 1'b1;
            end
            default: ;
        endcase
    end

    assign re_1    = if_valid & dec_use_rs;
    assign re_2    = if_valid & dec_use_rt;
    assign raddr_1 = rs;
    assign raddr_2 = rt;

    // The younger producer (EX) takes precedence over MEM.
    function automatic logic [31:0] fwd_operand(
        input logic        en,
        input logic [4:0]  addr,
        input logic [31:0] regval,
        input logic        fe_we,
        input logic [4:0]  fe_addr,
        input logic [31:0] fe_data,
        input logic        fm_we,
        input logic [4:0]  fm_addr,
        input logic [31:0] fm_data
    );
        if (!en || addr == 5'd0)               return 32'd0;
        else if (fe_we && fe_addr == addr)     return fe_data;
        else if (fm_we && fm_addr == addr)     return fm_data;
        else                                   return regval;
    endfunction

    logic [31:0] opnd_a;
    logic [31:0] opnd_b;

    assign opnd_a = fwd_operand(re_1, rs, rdata_1, ex_we, ex_waddr, ex_wdata,
                                mem_we, mem_waddr, mem_wdata);
    assign opnd_b = fwd_operand(re_2, rt, rdata_2, ex_we, ex_waddr, ex_wdata,
                                mem_we, mem_waddr, mem_wdata);

    logic hazard;

    assign hazard = if_valid & ex_is_load & ex_we & (ex_waddr != 5'd0)
                  & ((re_1 & (rs == ex_waddr)) | (re_2 & (rt == ex_waddr)));

    assign stall_req     = hazard | stall_in;
    assign branch_taken  = if_valid & ~stall_req
                         & ((dec_beq & (opnd_a == opnd_b)) | (dec_bne & (opnd_a != opnd_b)));
    assign branch_target = if_pc + 32'd4 + {imm_sext[29:0], 2'b00};

    logic [31:0] nxt_opnd2;
    logic [31:0] nxt_store_data;
    logic [4:0]  nxt_waddr;

    always_comb begin
        case (dec_src2)
            SRC2_ZEXT: nxt_opnd2 = {16'h0000, imm};
            SRC2_SEXT: nxt_opnd2 = imm_sext;
            SRC2_LUI:  nxt_opnd2 = {imm, 16'h0000};
            default:   nxt_opnd2 = opnd_b;
        endcase
    end

    // Branches carry their compared operands into ID/EX for visibility only.
    assign nxt_store_data = dec_mem_wr ? opnd_b : 32'd0;
    assign nxt_waddr      = dec_we ? (dec_dest_rd ? rd : rt) : 5'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_valid      <= 1'b0;
            idex_aluop      <= ALU_NOP;
            idex_opnd1      <= 32'd0;
            idex_opnd2      <= 32'd0;
            idex_store_data <= 32'd0;
            idex_waddr      <= 5'd0;
            idex_we         <= 1'b0;
            idex_mem_rd     <= 1'b0;
            idex_mem_wr     <= 1'b0;
        end else if (stall_in) begin
            idex_valid      <= idex_valid;
        end else if (hazard || !if_valid) begin
            idex_valid      <= 1'b0;
            idex_aluop      <= ALU_NOP;
            idex_opnd1      <= 32'd0;
            idex_opnd2      <= 32'd0;
            idex_store_data <= 32'd0;
            idex_waddr      <= 5'd0;
            idex_we         <= 1'b0;
            idex_mem_rd     <= 1'b0;
            idex_mem_wr     <= 1'b0;
        end else begin
            idex_valid      <= 1'b1;
            idex_aluop      <= dec_aluop;
            idex_opnd1      <= opnd_a;
            idex_opnd2      <= nxt_opnd2;
            idex_store_data <= nxt_store_data;
            idex_waddr      <= nxt_waddr;
            idex_we         <= dec_we;
            idex_mem_rd     <= dec_mem_rd;
            idex_mem_wr     <= dec_mem_wr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_id_stage
// Directed and random stimulus for id_stage against an instruction-level model.
// Rev    : 1.0
// ============================================================================
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc, if_inst;
    logic        if_valid;
    logic        re_1, re_2;
    logic [4:0]  raddr_1, raddr_2;
    logic [31:0] rdata_1, rdata_2;
    logic        ex_we, ex_is_load, mem_we;
    logic [4:0]  ex_waddr, mem_waddr;
    logic [31:0] ex_wdata, mem_wdata;
    logic        stall_in, stall_req, branch_taken;
    logic [31:0] branch_target;
    logic        idex_valid, idex_we, idex_mem_rd, idex_mem_wr;
    logic [3:0]  idex_aluop;
    logic [31:0] idex_opnd1, idex_opnd2, idex_store_data;
    logic [4:0]  idex_waddr;

    id_stage dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
        .re_1(re_1), .raddr_1(raddr_1), .rdata_1(rdata_1),
        .re_2(re_2), .raddr_2(raddr_2), .rdata_2(rdata_2),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .stall_in(stall_in), .stall_req(stall_req),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .idex_valid(idex_valid), .idex_aluop(idex_aluop), .idex_opnd1(idex_opnd1),
        .idex_opnd2(idex_opnd2), .idex_store_data(idex_store_data), .idex_waddr(idex_waddr),
        .idex_we(idex_we), .idex_mem_rd(idex_mem_rd), .idex_mem_wr(idex_mem_wr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [3:0]  aluop;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sd;
        logic [4:0]  waddr;
        logic        we;
        logic        mrd;
        logic        mwr;
    } idex_t;

    localparam int K_NOP = 0, K_R = 1, K_ORI = 2, K_ANDI = 3, K_ADDIU = 4;
    localparam int K_LUI = 5, K_LW = 6, K_SW = 7, K_BEQ = 8, K_BNE = 9;

    int    n_cmp = 0;
    int    n_err = 0;
    idex_t exp_q;
    idex_t m_dec;
    logic  m_r1, m_r2, m_haz, m_stall, m_taken;
    logic [31:0] m_a, m_b, m_target;
    logic  obs_stall, obs_taken;
    logic [31:0] obs_target;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] s,
                                           input logic [4:0] t, input logic [4:0] d);
        return {6'b000000, s, t, d, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s,
                                           input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [3:0] alu_of_funct(input logic [5:0] fn);
        case (fn)
            6'h21: return 4'd1;
            6'h23: return 4'd2;
            6'h24: return 4'd3;
            6'h25: return 4'd4;
            6'h26: return 4'd5;
            6'h2a: return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    function automatic int kind_of(input logic [31:0] i);
        case (i[31:26])
            6'h00: return (alu_of_funct(i[5:0]) != 4'd0) ? K_R : K_NOP;
            6'h0d: return K_ORI;
            6'h0c: return K_ANDI;
            6'h09: return K_ADDIU;
            6'h0f: return K_LUI;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            default: return K_NOP;
        endcase
    endfunction

    // Value a register read sees: newest producer first, then the regfile.
    function automatic logic [31:0] ref_fwd(input logic en, input logic [4:0] a,
                                            input logic [31:0] regval);
        if (!en || a == 5'd0) return 32'd0;
        if (ex_we && ex_waddr == a) return ex_wdata;
        if (mem_we && mem_waddr == a) return mem_wdata;
        return regval;
    endfunction

    task automatic model_eval();
        int          k  = kind_of(if_inst);
        logic [4:0]  rs = if_inst[25:21];
        logic [4:0]  rt = if_inst[20:16];
        logic [15:0] im = if_inst[15:0];
        logic [31:0] sx = {{16{im[15]}}, im};
        m_r1 = if_valid && (k inside {K_R, K_ORI, K_ANDI, K_ADDIU, K_LW, K_SW, K_BEQ, K_BNE});
        m_r2 = if_valid && (k inside {K_R, K_SW, K_BEQ, K_BNE});
        m_a  = ref_fwd(m_r1, rs, rdata_1);
        m_b  = ref_fwd(m_r2, rt, rdata_2);
        m_haz = if_valid && ex_is_load && ex_we && ex_waddr != 5'd0 &&
                ((m_r1 && rs == ex_waddr) || (m_r2 && rt == ex_waddr));
        m_stall  = m_haz || stall_in;
        m_taken  = if_valid && !m_stall &&
                   ((k == K_BEQ && m_a == m_b) || (k == K_BNE && m_a != m_b));
        m_target = if_pc + 32'd4 + sx * 32'd4;
        m_dec = '0;
        m_dec.valid = 1'b1;
        case (k)
            K_R:     begin m_dec.aluop = alu_of_funct(if_inst[5:0]); m_dec.op1 = m_a; m_dec.op2 = m_b;
                           m_dec.waddr = if_inst[15:11]; m_dec.we = 1'b1; end
            K_ORI:   begin m_dec.aluop = 4'd4; m_dec.op1 = m_a; m_dec.op2 = {16'h0, im};
                           m_dec.waddr = rt; m_dec.we = 1'b1; end
            K_ANDI:  begin m_dec.aluop = 4'd3; m_dec.op1 = m_a; m_dec.op2 = {16'h0, im};
                           m_dec.waddr = rt; m_dec.we = 1'b1; end
            K_ADDIU: begin m_dec.aluop = 4'd1; m_dec.op1 = m_a; m_dec.op2 = sx;
                           m_dec.waddr = rt; m_dec.we = 1'b1; end
            K_LUI:   begin m_dec.aluop = 4'd4; m_dec.op2 = {im, 16'h0};
                           m_dec.waddr = rt; m_dec.we = 1'b1; end
            K_LW:    begin m_dec.aluop = 4'd1; m_dec.op1 = m_a; m_dec.op2 = sx;
                           m_dec.waddr = rt; m_dec.we = 1'b1; m_dec.mrd = 1'b1; end
            K_SW:    begin m_dec.aluop = 4'd1; m_dec.op1 = m_a; m_dec.op2 = sx;
                           m_dec.sd = m_b; m_dec.mwr = 1'b1; end
            K_BEQ, K_BNE: begin m_dec.op1 = m_a; m_dec.op2 = m_b; end
            default: ;
        endcase
    endtask

    task automatic check_idex(input string tag);
        check({tag, ".valid"}, idex_valid,      exp_q.valid);
        check({tag, ".aluop"}, idex_aluop,      exp_q.aluop);
        check({tag, ".opnd1"}, idex_opnd1,      exp_q.op1);
        check({tag, ".opnd2"}, idex_opnd2,      exp_q.op2);
        check({tag, ".sdata"}, idex_store_data, exp_q.sd);
        check({tag, ".waddr"}, idex_waddr,      exp_q.waddr);
        check({tag, ".we"},    idex_we,         exp_q.we);
        check({tag, ".mrd"},   idex_mem_rd,     exp_q.mrd);
        check({tag, ".mwr"},   idex_mem_wr,     exp_q.mwr);
    endtask

    // Called just after a rising edge with the cycle's inputs already applied.
    task automatic run_cycle(input string tag);
        idex_t nxt;
        #1;
        model_eval();
        obs_stall  = stall_req;
        obs_taken  = branch_taken;
        obs_target = branch_target;
        check({tag, ".stall_req"}, stall_req, m_stall);
        check({tag, ".br_taken"}, branch_taken, m_taken);
        if (m_taken) check({tag, ".br_target"}, branch_target, m_target);
        check({tag, ".re_1"}, re_1, m_r1);
        check({tag, ".re_2"}, re_2, m_r2);
        if (m_r1) check({tag, ".raddr_1"}, raddr_1, if_inst[25:21]);
        if (m_r2) check({tag, ".raddr_2"}, raddr_2, if_inst[20:16]);
        nxt = stall_in ? exp_q : ((m_haz || !if_valid) ? idex_t'('0) : m_dec);
        @(posedge clk);
        #1;
        exp_q = nxt;
        check_idex(tag);
    endtask

    task automatic clear_fwd();
        ex_we = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0; ex_is_load = 1'b0;
        mem_we = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'd0; stall_in = 1'b0;
    endtask

    function automatic logic [5:0] pick_funct(input int i);
        case (i)
            0: return 6'h21; 1: return 6'h23; 2: return 6'h24; 3: return 6'h25;
            4: return 6'h26; 5: return 6'h2a; default: return 6'h00;
        endcase
    endfunction

    task automatic rand_inputs();
        int          k  = $urandom_range(0, 9);
        logic [4:0]  a  = 5'($urandom_range(0, 3));
        logic [4:0]  b  = 5'($urandom_range(0, 3));
        logic [4:0]  c  = 5'($urandom_range(0, 31));
        logic [15:0] im = 16'($urandom);
        case (k)
            0, 1: if_inst = r_type(pick_funct($urandom_range(0, 6)), a, b, c);
            2: if_inst = i_type(6'h0d, a, b, im);
            3: if_inst = i_type(6'h0c, a, b, im);
            4: if_inst = i_type(6'h09, a, b, im);
            5: if_inst = i_type(6'h0f, a, b, im);
            6: if_inst = i_type(6'h23, a, b, im);
            7: if_inst = i_type(6'h2b, a, b, im);
            8: if_inst = i_type(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, a, b, im);
            default: if_inst = $urandom;
        endcase
        if_pc      = $urandom & 32'hFFFF_FFFC;
        if_valid   = ($urandom_range(0, 7) != 0);
        rdata_1    = ($urandom_range(0, 1) != 0) ? $urandom : rdata_2;
        rdata_2    = $urandom;
        ex_we      = ($urandom_range(0, 1) != 0);
        ex_waddr   = 5'($urandom_range(0, 3));
        ex_wdata   = $urandom;
        ex_is_load = ($urandom_range(0, 3) == 0);
        mem_we     = ($urandom_range(0, 1) != 0);
        mem_waddr  = 5'($urandom_range(0, 3));
        mem_wdata  = $urandom;
        stall_in   = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        rst = 1'b0; if_pc = 32'd0; if_inst = 32'd0; if_valid = 1'b0;
        rdata_1 = 32'd0; rdata_2 = 32'd0;
        clear_fwd();
        repeat (2) @(posedge clk);
        #1;
        exp_q = '0;
        check_idex("reset");
        rst = 1'b1;

        if_valid = 1'b1; if_pc = 32'h0;
        if_inst = r_type(6'h21, 5'd1, 5'd2, 5'd3); rdata_1 = 32'd5; rdata_2 = 32'd7;
        run_cycle("addu");
        check("addu_aluop", idex_aluop, 32'd1);
        check("addu_op1", idex_opnd1, 32'd5);
        check("addu_op2", idex_opnd2, 32'd7);
        check("addu_waddr", idex_waddr, 32'd3);

        if_inst = i_type(6'h0d, 5'd1, 5'd4, 16'h00FF); rdata_1 = 32'h77;
        ex_we = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h10;
        mem_we = 1'b1; mem_waddr = 5'd1; mem_wdata = 32'h20;
        run_cycle("ori_ex");
        check("ori_ex_op1", idex_opnd1, 32'h10);
        check("ori_ex_op2", idex_opnd2, 32'h0000_00FF);
        ex_we = 1'b0;
        run_cycle("ori_mem");
        check("ori_mem_op1", idex_opnd1, 32'h20);
        if_inst = i_type(6'h0d, 5'd0, 5'd4, 16'h00FF);
        ex_we = 1'b1; ex_waddr = 5'd0;
        run_cycle("ori_r0");
        check("ori_r0_op1", idex_opnd1, 32'h0);

        // Asynchronous reset asserted mid-cycle while idex_we is set.
        #2 rst = 1'b0;
        #1;
        check("areset_we", idex_we, 32'd0);
        check("areset_valid", idex_valid, 32'd0);
        check("areset_op2", idex_opnd2, 32'd0);
        exp_q = '0;
        #1 rst = 1'b1;
        clear_fwd();
        if_inst = r_type(6'h21, 5'd1, 5'd2, 5'd3);
        run_cycle("post_reset");
        check("post_reset_valid", idex_valid, 32'd1);

        if_inst = r_type(6'h23, 5'd2, 5'd6, 5'd5); rdata_1 = 32'h1234; rdata_2 = 32'd3;
        ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd2; ex_wdata = 32'hDEAD;
        run_cycle("loaduse");
        check("loaduse_stall", obs_stall, 32'd1);
        check("loaduse_bubble", idex_valid, 32'd0);
        clear_fwd();
        mem_we = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'd9;
        run_cycle("loaduse_issue");
        check("loaduse_op1", idex_opnd1, 32'd9);
        check("loaduse_aluop", idex_aluop, 32'd2);

        clear_fwd();
        if_pc = 32'h100; rdata_1 = 32'h55; rdata_2 = 32'h55;
        if_inst = i_type(6'h04, 5'd1, 5'd2, 16'hFFFF);
        run_cycle("beq_back");
        check("beq_back_taken", obs_taken, 32'd1);
        check("beq_back_target", obs_target, 32'h100);
        if_inst = i_type(6'h04, 5'd1, 5'd2, 16'h0004);
        run_cycle("beq_fwd");
        check("beq_fwd_target", obs_target, 32'h114);
        if_inst = i_type(6'h05, 5'd1, 5'd2, 16'h0004);
        run_cycle("bne_eq");
        check("bne_eq_taken", obs_taken, 32'd0);

        if_inst = i_type(6'h23, 5'd1, 5'd7, 16'h0008); rdata_1 = 32'h1000;
        stall_in = 1'b1;
        run_cycle("hold1");
        check("hold1_stall", obs_stall, 32'd1);
        run_cycle("hold2");
        check("hold2_stall", obs_stall, 32'd1);
        stall_in = 1'b0;
        run_cycle("lw_issue");
        check("lw_mem_rd", idex_mem_rd, 32'd1);
        check("lw_op2", idex_opnd2, 32'd8);
        check("lw_waddr", idex_waddr, 32'd7);

        for (int n = 0; n < 500; n++) begin
            rand_inputs();
            run_cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
